// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external ALU between two valid/ready requesters.
// Optional grant statistics counters enabled by defining ALU_SHARE_ARBITER_STATS_EN.
module alu_share_arbiter #(
  parameter int WIDTH = 64,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_o,
  input  logic             alu_zero
`ifdef ALU_SHARE_ARBITER_STATS_EN
  ,
  output logic [31:0]      grant_cnt0,
  output logic [31:0]      grant_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] op_a_reg, op_b_reg, result_reg;
  logic [OP_W-1:0]  op_code_reg;
  logic             zero_reg;
  logic             grant_reg;
  logic             last_grant_reg;

  logic             grant;
  logic             accept;
  logic             rsp_done;

  // Sole requester wins; on a tie the one not served last time wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_reg;
    end
  end

  // Gated by rst_n so no ready is shown while reset is held.
  assign req0_ready = rst_n && (state_reg == IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state_reg == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign rsp0_valid  = (state_reg == RESP) && !grant_reg;
  assign rsp1_valid  = (state_reg == RESP) && grant_reg;
  assign rsp0_result = rsp0_valid ? result_reg : '0;
  assign rsp1_result = rsp1_valid ? result_reg : '0;
  assign rsp0_zero   = rsp0_valid && zero_reg;
  assign rsp1_zero   = rsp1_valid && zero_reg;
  assign rsp_done    = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  assign alu_a  = op_a_reg;
  assign alu_b  = op_b_reg;
  assign alu_op = op_code_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      op_code_reg    <= '0;
      result_reg     <= '0;
      zero_reg       <= 1'b0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_a_reg       <= grant ? req1_a  : req0_a;
        op_b_reg       <= grant ? req1_b  : req0_b;
        op_code_reg    <= grant ? req1_op : req0_op;
        grant_reg      <= grant;
        last_grant_reg <= grant;
      end
      // ALU is combinational; its output is valid while EXEC drives the operands.
      if (state_reg == EXEC) begin
        result_reg <= alu_o;
        zero_reg   <= alu_zero;
      end
    end
  end

`ifdef ALU_SHARE_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && (grant_cnt0 != 32'hFFFF_FFFF)) grant_cnt0 <= grant_cnt0 + 32'd1;
      if (req1_ready && (grant_cnt1 != 32'hFFFF_FFFF)) grant_cnt1 <= grant_cnt1 + 32'd1;
    end
  end
`endif

endmodule
